// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and forwarding encodings for the pipeline hazard scoreboard.
// Tag destinations are stored at a fixed width so the struct is register-count agnostic.
package hazard_pkg;

   localparam int DST_W  = 8;
   localparam int FWD_RF = 0;
   localparam int FWD_W  = 1;

   typedef struct packed {
      logic             valid;
      logic [DST_W-1:0] dst;
      logic             rw;
      logic             ld;
   } hz_tag_t;

   function automatic int fwd_m(input int k);
      return k + 1;
   endfunction

   function automatic int PC_REG(input int nregs);
      return nregs - 1;
   endfunction

   // A stage can supply a result if it writes; memory stages only once the value is not a pending load.
   function automatic logic fwd_ok(input hz_tag_t t, input logic ld_ok);
      return t.valid & t.rw & (ld_ok | ~t.ld);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/Execute hazard inputs and pipeline-control outputs of the hazard scoreboard.
interface hazard_scoreboard_if #(
   parameter int NREGS   = 16,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
);
   localparam int AW     = $clog2(NREGS);
   localparam int FSEL_W = $clog2(MEM_LAT + 2);

   logic [AW-1:0]     ra1d;
   logic [AW-1:0]     ra2d;
   logic [AW-1:0]     wa3d;
   logic              regwrite_d;
   logic              memtoreg_d;
   logic              valid_d;
   logic              cond_ex_e;
   logic              branch_taken_e;
   logic              stall_f;
   logic              stall_d;
   logic              flush_d;
   logic              flush_e;
   logic [FSEL_W-1:0] forward_ae;
   logic [FSEL_W-1:0] forward_be;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   modport master (
      output ra1d, ra2d, wa3d, regwrite_d, memtoreg_d, valid_d, cond_ex_e, branch_taken_e,
      input  stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be, stall_count, flush_count
   );

   modport slave (
      input  ra1d, ra2d, wa3d, regwrite_d, memtoreg_d, valid_d, cond_ex_e, branch_taken_e,
      output stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_scoreboard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count qualifying cycles, holding at the maximum value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit with its own E..W tag pipeline: load-use stalls, PC-write stalls, flushes,
// operand forwarding selects and saturating stall/flush event counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREGS   = 16,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input logic          clk,
   input logic          reset,
   hazard_scoreboard_if.slave hz
);

   localparam int AW     = $clog2(NREGS);
   localparam int FSEL_W = $clog2(MEM_LAT + 2);
   localparam logic [DST_W-1:0] PC_DST = DST_W'(PC_REG(NREGS));
   localparam logic [AW-1:0]    PC_SRC = AW'(PC_REG(NREGS));

   hz_tag_t           tag_e;
   hz_tag_t           tag_m [MEM_LAT];
   hz_tag_t           tag_w;
   logic [AW-1:0]     ra1e;
   logic [AW-1:0]     ra2e;
   logic              ldstall;
   logic              pcpend;
   logic              d_pc_write;
   logic              e_pc_write;
   logic              stall_f;
   logic              stall_d;
   logic              flush_d;
   logic              flush_e;
   logic [FSEL_W-1:0] fwd_a;
   logic [FSEL_W-1:0] fwd_b;

   // Load-use detection and PC-write-in-flight detection across the tag pipeline.
   always_comb begin
      d_pc_write = hz.regwrite_d && (hz.wa3d == PC_SRC);
      e_pc_write = tag_e.valid && tag_e.rw && (tag_e.dst == PC_DST);
      // E is deliberately not qualified by cond_ex_e here.
      ldstall = hz.valid_d && tag_e.valid && tag_e.rw && tag_e.ld &&
                ((tag_e.dst == DST_W'(hz.ra1d)) || (tag_e.dst == DST_W'(hz.ra2d)));
      pcpend  = d_pc_write || e_pc_write ||
                (tag_w.valid && tag_w.rw && (tag_w.dst == PC_DST));
      for (int k = 0; k < MEM_LAT; k++) begin
         ldstall = ldstall || (hz.valid_d && tag_m[k].valid && tag_m[k].rw && tag_m[k].ld &&
                   ((tag_m[k].dst == DST_W'(hz.ra1d)) || (tag_m[k].dst == DST_W'(hz.ra2d))));
         pcpend  = pcpend || (tag_m[k].valid && tag_m[k].rw && (tag_m[k].dst == PC_DST));
      end
   end

   // Forward selects: start from W, then let younger memory stages override.
   always_comb begin
      fwd_a = (fwd_ok(tag_w, 1'b1) && (tag_w.dst == DST_W'(ra1e))) ? FSEL_W'(FWD_W) : FSEL_W'(FWD_RF);
      fwd_b = (fwd_ok(tag_w, 1'b1) && (tag_w.dst == DST_W'(ra2e))) ? FSEL_W'(FWD_W) : FSEL_W'(FWD_RF);
      for (int k = MEM_LAT; k >= 1; k--) begin
         fwd_a = (fwd_ok(tag_m[k-1], 1'b0) && (tag_m[k-1].dst == DST_W'(ra1e))) ? FSEL_W'(fwd_m(k)) : fwd_a;
         fwd_b = (fwd_ok(tag_m[k-1], 1'b0) && (tag_m[k-1].dst == DST_W'(ra2e))) ? FSEL_W'(fwd_m(k)) : fwd_b;
      end
      fwd_a = (ra1e == PC_SRC) ? FSEL_W'(FWD_RF) : fwd_a;
      fwd_b = (ra2e == PC_SRC) ? FSEL_W'(FWD_RF) : fwd_b;
   end

   // Control outputs; a taken branch overrides stalls since Decode holds a wrong-path instruction.
   always_comb begin
      if (reset) begin
         stall_f = 1'b0;
         stall_d = 1'b0;
         flush_e = 1'b0;
         flush_d = d_pc_write;
      end else if (hz.branch_taken_e) begin
         stall_f = e_pc_write;
         stall_d = 1'b0;
         flush_e = 1'b1;
         flush_d = 1'b1;
      end else begin
         stall_f = ldstall || pcpend;
         stall_d = ldstall;
         flush_e = ldstall;
         flush_d = pcpend;
      end
   end

   // Tag pipeline: advances every cycle, E takes a bubble when flushed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_e <= '0;
         ra1e  <= '0;
         ra2e  <= '0;
         tag_w <= '0;
         for (int k = 0; k < MEM_LAT; k++) begin
            tag_m[k] <= '0;
         end
      end else begin
         if (flush_e) begin
            tag_e <= '0;
            ra1e  <= '0;
            ra2e  <= '0;
         end else begin
            tag_e <= '{valid: hz.valid_d, dst: DST_W'(hz.wa3d),
                       rw: hz.regwrite_d & hz.valid_d, ld: hz.memtoreg_d};
            ra1e  <= hz.ra1d;
            ra2e  <= hz.ra2d;
         end
         tag_m[0] <= '{valid: tag_e.valid, dst: tag_e.dst, rw: tag_e.rw & hz.cond_ex_e, ld: tag_e.ld};
         for (int k = 1; k < MEM_LAT; k++) begin
            tag_m[k] <= tag_m[k-1];
         end
         tag_w <= tag_m[MEM_LAT-1];
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_f),
      .count (hz.stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_e),
      .count (hz.flush_count)
   );

   assign hz.stall_f    = stall_f;
   assign hz.stall_d    = stall_d;
   assign hz.flush_d    = flush_d;
   assign hz.flush_e    = flush_e;
   assign hz.forward_ae = fwd_a;
   assign hz.forward_be = fwd_b;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised scoreboard bench for hazard_scoreboard: two instances (MEM_LAT=1/CNT_W=16 and
// MEM_LAT=3/CNT_W=4) share stimulus and are checked against an instruction-level model.
module tb_hazard_scoreboard;

   typedef struct {
      bit rw;
      bit ld;
      int dst;
      int s1;
      int s2;
   } ins_t;

   typedef struct {
      int sf;
      int sd;
      int fd;
      int fe;
      int fa;
      int fb;
      int sc;
      int fc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.NREGS(16), .MEM_LAT(1), .CNT_W(16)) hz1 ();
   hazard_scoreboard_if #(.NREGS(16), .MEM_LAT(3), .CNT_W(4))  hz3 ();

   hazard_scoreboard #(.NREGS(16), .MEM_LAT(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .hz(hz1));
   hazard_scoreboard #(.NREGS(16), .MEM_LAT(3), .CNT_W(4))  dut3 (.clk(clk), .reset(reset), .hz(hz3));

   int   n_checks = 0;
   int   n_fail   = 0;
   ins_t pipe [2][6];
   int   lat  [2] = '{1, 3};
   int   cmax [2] = '{65535, 15};
   int   scnt [2];
   int   fcnt [2];
   exp_t prev_exp [2];
   exp_t expq0 [$];
   exp_t expq1 [$];

   int in_ra1, in_ra2, in_wa3;
   bit in_rw, in_ld, in_v, in_cond, in_br;
   bit in_rst = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Youngest producing stage (M1 first, W last) for a source register; loads forward only from W.
   function automatic int fwd(input int c, input int src);
      int l = lat[c];
      if (src == 15) return 0;
      for (int i = 1; i <= l + 1; i++) begin
         if (pipe[c][i].rw && pipe[c][i].dst == src && (i == l + 1 || !pipe[c][i].ld))
            return (i == l + 1) ? 1 : i + 1;
      end
      return 0;
   endfunction

   function automatic exp_t predict(input int c);
      exp_t e;
      int   l   = lat[c];
      bit   lds = 1'b0;
      bit   dpc = in_rw && (in_wa3 == 15);
      bit   pcs = dpc;
      bit   epc = pipe[c][0].rw && (pipe[c][0].dst == 15);
      for (int i = 0; i <= l; i++)
         if (in_v && pipe[c][i].rw && pipe[c][i].ld &&
             (pipe[c][i].dst == in_ra1 || pipe[c][i].dst == in_ra2)) lds = 1'b1;
      for (int i = 0; i <= l + 1; i++)
         if (pipe[c][i].rw && pipe[c][i].dst == 15) pcs = 1'b1;
      if (in_rst) begin
         e.sf = 0; e.sd = 0; e.fe = 0; e.fd = int'(dpc);
      end else begin
         e.sf = in_br ? int'(epc) : int'(lds | pcs);
         e.sd = int'(lds && !in_br);
         e.fe = int'(lds | in_br);
         e.fd = int'(pcs | in_br);
      end
      e.fa = fwd(c, pipe[c][0].s1);
      e.fb = fwd(c, pipe[c][0].s2);
      e.sc = scnt[c];
      e.fc = fcnt[c];
      return e;
   endfunction

   task automatic clear_model(input int c);
      for (int i = 0; i < 6; i++) pipe[c][i] = '{0, 0, 0, 0, 0};
      scnt[c] = 0;
      fcnt[c] = 0;
   endtask

   // Apply the rising edge to the model using the inputs of the cycle just ended.
   task automatic advance();
      for (int c = 0; c < 2; c++) begin
         if (in_rst) begin
            clear_model(c);
         end else begin
            for (int i = lat[c] + 1; i >= 1; i--) pipe[c][i] = pipe[c][i-1];
            pipe[c][1].rw = pipe[c][1].rw && in_cond;
            if (prev_exp[c].fe != 0) pipe[c][0] = '{0, 0, 0, 0, 0};
            else pipe[c][0] = '{in_rw && in_v, in_ld, in_wa3, in_ra1, in_ra2};
            if (prev_exp[c].sf != 0 && scnt[c] < cmax[c]) scnt[c]++;
            if (prev_exp[c].fe != 0 && fcnt[c] < cmax[c]) fcnt[c]++;
         end
      end
   endtask

   task automatic step(input bit rst, input int ra1, input int ra2, input int wa3,
                       input bit rw, input bit ld, input bit v, input bit cond, input bit br);
      @(posedge clk);
      advance();
      #1;
      in_rst = rst; in_ra1 = ra1; in_ra2 = ra2; in_wa3 = wa3;
      in_rw = rw; in_ld = ld; in_v = v; in_cond = cond; in_br = br;
      reset = rst;
      hz1.ra1d = 4'(ra1); hz1.ra2d = 4'(ra2); hz1.wa3d = 4'(wa3);
      hz1.regwrite_d = rw; hz1.memtoreg_d = ld; hz1.valid_d = v;
      hz1.cond_ex_e = cond; hz1.branch_taken_e = br;
      hz3.ra1d = 4'(ra1); hz3.ra2d = 4'(ra2); hz3.wa3d = 4'(wa3);
      hz3.regwrite_d = rw; hz3.memtoreg_d = ld; hz3.valid_d = v;
      hz3.cond_ex_e = cond; hz3.branch_taken_e = br;
      if (rst) begin
         clear_model(0);
         clear_model(1);
      end
      prev_exp[0] = predict(0);
      prev_exp[1] = predict(1);
      expq0.push_back(prev_exp[0]);
      expq1.push_back(prev_exp[1]);
   endtask

   task automatic idle(input bit rst);
      step(rst, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic check_all(input string t, input exp_t e, input int sf, input int sd, input int fd,
                            input int fe, input int fa, input int fb, input int sc, input int fc);
      chk({t, ".stall_f"}, sf, e.sf);
      chk({t, ".stall_d"}, sd, e.sd);
      chk({t, ".flush_d"}, fd, e.fd);
      chk({t, ".flush_e"}, fe, e.fe);
      chk({t, ".forward_ae"}, fa, e.fa);
      chk({t, ".forward_be"}, fb, e.fb);
      chk({t, ".stall_count"}, sc, e.sc);
      chk({t, ".flush_count"}, fc, e.fc);
   endtask

   // Monitor: compare each presented cycle against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (expq0.size() > 0) begin
         e = expq0.pop_front();
         check_all("lat1", e, int'(hz1.stall_f), int'(hz1.stall_d), int'(hz1.flush_d), int'(hz1.flush_e),
                   int'(hz1.forward_ae), int'(hz1.forward_be), int'(hz1.stall_count), int'(hz1.flush_count));
      end
      if (expq1.size() > 0) begin
         e = expq1.pop_front();
         check_all("lat3", e, int'(hz3.stall_f), int'(hz3.stall_d), int'(hz3.flush_d), int'(hz3.flush_e),
                   int'(hz3.forward_ae), int'(hz3.forward_be), int'(hz3.stall_count), int'(hz3.flush_count));
      end
   end

   function automatic int rnd_reg();
      int r = int'($urandom_range(0, 9));
      return (r < 8) ? (r % 4) : 15;
   endfunction

   initial begin
      int st1, st3;
      int r;
      bit rw, ld, br;
      st1 = 0;
      st3 = 0;
      idle(1'b1);
      idle(1'b1);

      // ALU dependency: ADD R1, then SUB reading R1, then another consumer.
      step(0, 0, 0, 1, 1, 0, 1, 1, 0);
      step(0, 1, 0, 5, 1, 0, 1, 1, 0);
      step(0, 1, 1, 6, 1, 0, 1, 1, 0);
      idle(0); idle(0); idle(0);

      // Load-use: LDR R2 then ADD R3,R2 held in Decode.
      idle(1'b1);
      step(0, 0, 0, 2, 1, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 2, 3, 1, 0, 1, 1, 0);
         #2;
         st1 += int'(hz1.stall_d);
         st3 += int'(hz3.stall_d);
      end
      idle(0);
      #2;
      chk("loaduse_stall_cycles_lat1", st1, 2);
      chk("loaduse_stall_cycles_lat3", st3, 4);
      chk("loaduse_stall_count_lat1", int'(hz1.stall_count), 2);
      chk("loaduse_flush_count_lat1", int'(hz1.flush_count), 2);
      chk("loaduse_stall_count_lat3", int'(hz3.stall_count), 4);
      idle(0); idle(0); idle(0);

      // Branch taken while a load-use condition is present.
      step(0, 0, 0, 2, 1, 1, 1, 1, 0);
      step(0, 2, 0, 3, 1, 0, 1, 1, 1);
      step(0, 2, 0, 3, 1, 0, 1, 1, 0);
      idle(0); idle(0); idle(0); idle(0);

      // Condition-failed PC write, then condition-failed write to R4 with a consumer.
      step(0, 0, 0, 15, 1, 0, 1, 1, 0);
      step(0, 0, 0, 4, 1, 0, 1, 0, 0);
      step(0, 4, 4, 7, 1, 0, 1, 0, 0);
      step(0, 4, 4, 7, 0, 0, 1, 1, 0);
      idle(0); idle(0); idle(0); idle(0);

      // Reset in the middle of a PC write.
      step(0, 0, 0, 15, 1, 0, 1, 1, 0);
      idle(0);
      step(1, 0, 0, 15, 1, 0, 1, 1, 1);
      idle(0);

      // Saturation of the narrow counter.
      idle(1'b1);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 15, 1, 0, 1, 1, 0);
      idle(0); idle(0); idle(0); idle(0); idle(0);
      #2;
      chk("saturate_stall_count_lat3", int'(hz3.stall_count), 15);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         rw = ($urandom_range(0, 9) < 6);
         ld = rw && ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 11) == 0);
         r  = int'($urandom_range(0, 79));
         step(r == 0, rnd_reg(), rnd_reg(), rnd_reg(), rw, ld,
              $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, br);
      end
      idle(0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline hazard unit for the pipelined ARM-subset core. It adds memory latency configurable via `MEM_LAT` and a configurable register count. It keeps its own registered tag pipeline (destination, write-enable, load flag) from Execute to Writeback, so the datapath only supplies Decode-stage tags. It produces stall, flush and forwarding selects, and it maintains saturating stall/flush event counters for demonstration builds.

## Interface
- `NREGS`, 16, architectural register count; index `NREGS-1` is the PC.
- `MEM_LAT`, 1, memory stages between Execute and Writeback (M1..M`MEM_LAT`); legal range 1..4.
- `CNT_W`, 16, width of the event counters.
- `FSEL_W` (derived), clog2(`MEM_LAT`+2), width of the forward selects.
- `clk` in 1: the single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `ra1d`, `ra2d` in clog2(`NREGS`): Decode source register indices.
- `wa3d` in clog2(`NREGS`): Decode destination index.
- `regwrite_d`, `memtoreg_d`, `valid_d` in 1: Decode write-enable, load flag, and instruction valid.
- `cond_ex_e` in 1: Execute condition passed; qualifies the Execute write-enable.
- `branch_taken_e` in 1: branch resolved taken in Execute.
- `stall_f`, `stall_d`, `flush_d`, `flush_e` out 1: pipeline control.
- `forward_ae`, `forward_be` out `FSEL_W`: operand selects for Execute.
- `stall_count`, `flush_count` out `CNT_W`: saturating event counters.

## Operation
- **Tag pipeline.** Entries E, M1..M`MEM_LAT`, W; each entry holds {valid, dst, rw, ld}.
- **Advance.** The pipeline advances every cycle with no internal stall.
- **E entry load.** E loads {`valid_d`, `wa3d`, `regwrite_d`&`valid_d`, `memtoreg_d`} from Decode.
  - When `flush_e`=1, E loads a bubble (all zero) instead.
- **E to M1.** M1.rw = E.rw & `cond_ex_e`.
- **Forward encoding.** 0 selects the register file, 1 selects W, k+1 selects Mk.
- **Forward select rule.** `forward_ae` picks the youngest stage among M1..M`MEM_LAT`, W that satisfies all of:
  - rw=1
  - dst = E's registered source index `ra1e` (latched alongside the E tag)
  - ld=0 for M stages; W qualifies regardless of ld.
  - `forward_be` is the same rule applied to `ra2e`. If no stage matches, the select is 0.
- **PC reads.** A source equal to `NREGS-1` is never forwarded (select 0).
- **Load-use stall.** `ldstall` = the E or any M stage has ld=1, rw=1 and dst equal to `ra1d` or `ra2d` (with `valid_d`=1).
  - The E stage's rw here is not qualified by `cond_ex_e`; this is conservative.
- **PC-write pending.** `pcpend` = Decode has `regwrite_d` with `wa3d`=`NREGS-1`, or any of E..W has rw=1 with dst=`NREGS-1`.
- **Control equations.**
  - `stall_f` = `ldstall` | `pcpend`
  - `stall_d` = `ldstall`
  - `flush_e` = `ldstall` | `branch_taken_e`
  - `flush_d` = `pcpend` | `branch_taken_e`
- **Priority.** When `branch_taken_e`=1, `stall_d` is forced to 0, because the Decode instruction is wrong-path. `stall_f` is forced to 0 unless the branch itself writes the PC.
- **Counters.**
  - `stall_count` increments on every cycle with `stall_f`=1.
  - `flush_count` increments on every cycle with `flush_e`=1.
  - Both counters saturate at all-ones and never wrap.

## Timing
- **Reset values.** While `reset` is asserted, all tag entries are invalid and both counters are 0. Therefore `stall_f`=`stall_d`=`flush_e`=0 and `forward_ae`=`forward_be`=0. `flush_d` follows the combinational `pcpend` from the Decode inputs only.
- **Combinational outputs.** Controls and forwards are combinational from the registered tags plus the current inputs, with zero-cycle latency. Counters update one cycle after the event.
- **Load-use stall duration.** For a load followed immediately by a dependent instruction, the stall lasts `MEM_LAT`+1 cycles. With `MEM_LAT`=1 this is 2 cycles, after which the operand forwards from W.
- **PC-write duration.** A PC write holds `stall_f` for `MEM_LAT`+3 consecutive cycles: D, E, M1..M`MEM_LAT`, W.
- **Same-cycle writers.** If two stages write the same dst, the younger stage wins. If the only match is in W, the select is 1.
- **Reset mid-stall.** Stall and flush drop on the same cycle reset is asserted; the pipeline restarts empty.

## Structure
- Package `hazard_pkg`:
  - forward-encoding constants `FWD_RF`=0 and `FWD_W`=1, plus function `fwd_m(k)`=k+1
  - `PC_REG` function of `NREGS`
  - packed struct `hz_tag_t` {valid, dst, rw, ld}
- Sub-module `sat_counter` (`CNT_W`, `clk`, `reset`, `inc`, `count`), instantiated twice.

## Test plan
- **ALU dependency.** `MEM_LAT`=1: ADD R1 in E, then dependent SUB reads R1.
  - Next cycle `forward_ae`=2 (M1); the cycle after, a consumer sees `forward_ae`=1 (W).
- **Load-use.** LDR R2 then ADD R3,R2.
  - `stall_f`=`stall_d`=`flush_e`=1 for exactly 2 cycles, then `forward_be`=1.
  - `stall_count`=2 and `flush_count`=2.
- **Deeper memory.** `MEM_LAT`=3 with the same load-use sequence.
  - Stall lasts 4 cycles; `FSEL_W`=3.
  - An ALU result in M3 forwards with select 4.
- **Branch during load-use.** `branch_taken_e`=1 while a load-use condition exists.
  - `flush_d`=`flush_e`=1 and `stall_d`=0; next cycle E holds a bubble.
- **Condition-failed write.** MOV R15 with `cond_ex_e`=0.
  - `pcpend` clears once the entry leaves E.
  - The write to R4 with `cond_ex_e`=0 produces no forward (select 0).
- **Reset and saturation.** Assert `reset` mid-PC-write.
  - All outputs go to their reset values immediately.
  - Forcing `CNT_W`=4 and stalling 20 cycles gives `stall_count`=15.
